// File: rtl/bmi_bit_deposit_seq.sv
`default_nettype none
// ============================================================================
// Module      : bmi_bit_deposit_seq
// Description : Sequential bit-deposit (PDEP) engine for the BMI ALU.
//               The low-order bits of src are scattered, in order, into the
//               set bit positions of mask; all other result bits are zero.
//               One bit position is processed per cycle, and the operation
//               ends early once no mask bits remain above the current position.
//
// Ports       : clk    - system clock, rising-edge active
//               rst    - synchronous active-high reset
//               start  - request, sampled only while idle
//               src    - source bits to deposit (LSB first), sampled with start
//               mask   - deposit positions, sampled with start
//               busy   - high while an operation is running or completing
//               done   - one-cycle pulse; result is final in this cycle
//               result - deposit result, held from done until the next start
//
// Revision    : 1.0 - initial release
// ============================================================================
module bmi_bit_deposit_seq #(
    parameter int WIDTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] mask,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_src_sh;   // remaining source bits, next one at bit 0
    logic [WIDTH-1:0] r_mask_sh;  // remaining mask bits, current one at bit 0
    logic [WIDTH-1:0] r_result;
    logic [IDX_W-1:0] r_pos;      // result position that r_mask_sh[0] maps to
    logic             r_busy;
    logic             r_done;

    // Mask contents after this cycle's shift; when nothing is left, the
    // current position is the last one that can deposit a bit.
    logic [WIDTH-1:0] w_mask_nxt;
    logic             w_mask_empty_nxt;
    logic             w_accept;

    assign w_mask_nxt       = r_mask_sh >> 1;
    assign w_mask_empty_nxt = (w_mask_nxt == '0);

    // A request is only taken in IDLE; start while busy or in DONE is dropped.
    assign w_accept         = (r_state == ST_IDLE) && start;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // An empty mask has nothing to deposit: finish immediately.
                    if (mask == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_mask_empty_nxt) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_sh  <= '0;
            r_mask_sh <= '0;
            r_result  <= '0;
            r_pos     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_src_sh  <= src;
                        r_mask_sh <= mask;
                        r_result  <= '0;
                        r_pos     <= '0;
                    end
                end
                ST_RUN: begin
                    // Consume a source bit only where the mask selects a slot;
                    // unselected positions stay at the cleared value of zero.
                    if (r_mask_sh[0]) begin
                        r_result[r_pos] <= r_src_sh[0];
                        r_src_sh        <= r_src_sh >> 1;
                    end
                    r_mask_sh <= w_mask_nxt;
                    // Termination occurs no later than the top position, so the
                    // increment out of the last position is never observed.
                    r_pos     <= r_pos + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status outputs, registered from the next state so they track the state
    // register exactly and are free of decode glitches.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_bmi_bit_deposit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmi_bit_deposit_seq
// Description : Scoreboard bench for bmi_bit_deposit_seq. Each accepted
//               request pushes its hand-computed result and done cycle; a
//               monitor pops an entry on every done pulse and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmi_bit_deposit_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] src = '0;
    logic [63:0] mask = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t q[$];

    bmi_bit_deposit_seq #(.WIDTH(64), .IDX_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .src    (src),
        .mask   (mask),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", result, e.res);
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one start pulse from a negedge; optionally register the expected
    // outcome. lat is the done cycle counted from the start-sampling edge.
    task automatic issue(input logic [63:0] s, input logic [63:0] m,
                         input logic [63:0] exp_res, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        src   = s;
        mask  = m;
        start = 1'b1;
        if (push) begin
            e.res = exp_res;
            e.cyc = cyc + lat;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_result", result, 64'd0);
        end

        // Basic case, plus busy rise and hold after done.
        issue(64'hFF, 64'hF0F0, 64'hF0F0, 17, 1'b1);
        check("busy_rise", 64'(busy), 64'd1);
        wait_idle();
        repeat (2) @(negedge clk);
        check("result_hold", result, 64'hF0F0);
        check("idle_busy", 64'(busy), 64'd0);

        issue(64'hA, 64'hF0, 64'hA0, 9, 1'b1);
        wait_idle();

        issue(64'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65, 1'b1);
        wait_idle();

        issue(64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h0123_4567_89AB_CDEF, 65, 1'b1);
        wait_idle();

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1, 1'b1);
        wait_idle();

        // Start while busy is ignored.
        issue(64'hFF, 64'hFF00, 64'hFF00, 17, 1'b1);   // returns in cycle 1
        @(negedge clk);                                // cycle 2
        src   = 64'hFFFF;
        mask  = 64'h1;
        start = 1'b1;
        @(negedge clk);                                // cycle 3
        start = 1'b0;
        wait_idle();

        // Reset mid-operation abandons it with no done pulse.
        issue(64'hFF, 64'hFF00, 64'h0, 0, 1'b0);       // cycle 1
        repeat (3) @(negedge clk);                     // cycle 4
        rst = 1'b1;
        @(negedge clk);                                // cycle 5: reset edge follows
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_result", result, 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        repeat (20) @(negedge clk);

        // Fresh operation after the abandoned one.
        issue(64'h3, 64'h5, 64'h5, 4, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
